// File: rtl/hm_mem_arb.sv
// Two-requester round-robin arbiter for a single synchronous memory port.
// Build with HM_MEM_ARB_STATS_EN defined to get saturating per-requester grant counters.
module hm_mem_arb (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        m0_req,
  input  logic [3:0]  m0_we,
  input  logic [15:0] m0_adr,
  input  logic [31:0] m0_dat_w,
  output logic        m0_ack,
  output logic [31:0] m0_dat_r,
  input  logic        m1_req,
  input  logic [3:0]  m1_we,
  input  logic [15:0] m1_adr,
  input  logic [31:0] m1_dat_w,
  output logic        m1_ack,
  output logic [31:0] m1_dat_r,
  output logic [15:0] mem_adr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_di,
  input  logic [31:0] mem_do,
  output logic [15:0] m0_grants,
  output logic [15:0] m1_grants
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_win;
  logic [15:0] r_adr;
  logic [31:0] r_di;
  logic [3:0]  r_mem_we;
  logic        r_ack0, r_ack1;
  logic [31:0] r_dat0, r_dat1;

  logic w_any;
  logic w_pick;

  assign w_any  = m0_req | m1_req;
  // On a tie the requester that was not served last wins.
  assign w_pick = (m0_req & m1_req) ? ~r_last : m1_req;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_win    <= 1'b0;
      r_adr    <= '0;
      r_di     <= '0;
      r_mem_we <= '0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_dat0   <= '0;
      r_dat1   <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win    <= w_pick;
            r_last   <= w_pick;
            r_adr    <= w_pick ? m1_adr   : m0_adr;
            r_di     <= w_pick ? m1_dat_w : m0_dat_w;
            r_mem_we <= w_pick ? m1_we    : m0_we;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Memory samples address/we on this edge; write strobe lasts exactly one cycle.
          r_mem_we <= '0;
          r_state  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (r_win) begin
            r_dat1 <= mem_do;
            r_ack1 <= 1'b1;
          end else begin
            r_dat0 <= mem_do;
            r_ack0 <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_adr  = r_adr;
  assign mem_di   = r_di;
  assign mem_we   = r_mem_we;
  assign m0_ack   = r_ack0;
  assign m1_ack   = r_ack1;
  assign m0_dat_r = r_dat0;
  assign m1_dat_r = r_dat1;

`ifdef HM_MEM_ARB_STATS_EN
  logic [15:0] r_gcnt0, r_gcnt1;
  logic        w_grant;

  assign w_grant = (r_state == S_IDLE) & w_any;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
    end else if (w_grant) begin
      if (w_pick) begin
        if (r_gcnt1 != 16'hFFFF) r_gcnt1 <= r_gcnt1 + 16'd1;
      end else begin
        if (r_gcnt0 != 16'hFFFF) r_gcnt0 <= r_gcnt0 + 16'd1;
      end
    end
  end

  assign m0_grants = r_gcnt0;
  assign m1_grants = r_gcnt1;
`else
  assign m0_grants = 16'h0000;
  assign m1_grants = 16'h0000;
`endif

endmodule

// File: tb/tb_hm_mem_arb.sv
// Self-checking bench for hm_mem_arb: directed table, tie/alternation, reset abort, random traffic.
module tb_hm_mem_arb;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [3:0]  m0_we = '0, m1_we = '0;
  logic [15:0] m0_adr = '0, m1_adr = '0;
  logic [31:0] m0_dat_w = '0, m1_dat_w = '0;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_dat_r, m1_dat_r;
  logic [15:0] mem_adr;
  logic [3:0]  mem_we;
  logic [31:0] mem_di;
  logic [31:0] mem_do = '0;
  logic [15:0] m0_grants, m1_grants;

  hm_mem_arb dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_w(m0_dat_w),
    .m0_ack(m0_ack), .m0_dat_r(m0_dat_r),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_w(m1_dat_w),
    .m1_ack(m1_ack), .m1_dat_r(m1_dat_r),
    .mem_adr(mem_adr), .mem_we(mem_we), .mem_di(mem_di), .mem_do(mem_do),
    .m0_grants(m0_grants), .m1_grants(m1_grants)
  );

  always #5 sys_clk = ~sys_clk;

  // Initial memory image: byte at address a holds a[7:0].
  function automatic logic [31:0] pat(input int i);
    pat = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
  endfunction

  // Read-first synchronous memory, DO registered one clock after address.
  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;
  always @(posedge sys_clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      mem_init <= 1'b1;
    end else begin
      mem_do <= mem[mem_adr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_adr[9:2]][8*b +: 8] <= mem_di[8*b +: 8];
    end
  end

  // Reference model state: shadow memory plus expected grant totals.
  logic [31:0] shadow [0:255];
  int g0, g1;
  int nchk = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void shadow_wr(input logic [15:0] adr, input logic [3:0] we, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (we[b]) shadow[adr[9:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic drive(input int m, input logic rq, input logic [3:0] we,
                       input logic [15:0] adr, input logic [31:0] d);
    if (m == 0) begin m0_req = rq; m0_we = we; m0_adr = adr; m0_dat_w = d; end
    else        begin m1_req = rq; m1_we = we; m1_adr = adr; m1_dat_w = d; end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    g0 = 0; g1 = 0;
  endtask

  // One isolated access; inputs are scrambled after the issue cycle to prove they were latched.
  task automatic do_access(input string nm, input int m, input logic [3:0] we,
                           input logic [15:0] adr, input logic [31:0] d, input logic [31:0] exp);
    int lat, wec;
    logic done, oth_ack;
    logic [31:0] oth_dat, rd;
    @(negedge sys_clk);
    oth_dat = (m == 0) ? m1_dat_r : m0_dat_r;
    drive(m, 1'b1, we, adr, d);
    lat = 0; wec = 0; done = 1'b0; oth_ack = 1'b0; rd = '0;
    while (!done && lat < 10) begin
      @(negedge sys_clk);
      lat++;
      if (mem_we != 4'b0000) begin
        wec++;
        chk({nm, ".mem_we"}, 32'(mem_we), 32'(we));
        chk({nm, ".mem_adr"}, 32'(mem_adr), 32'(adr));
        chk({nm, ".mem_di"}, mem_di, d);
      end
      if (lat == 1) drive(m, 1'b1, ~we, ~adr & 16'h00FC, ~d);
      if ((m == 0) ? m0_ack : m1_ack) begin
        done = 1'b1;
        rd = (m == 0) ? m0_dat_r : m1_dat_r;
        oth_ack = (m == 0) ? m1_ack : m0_ack;
      end
    end
    drive(m, 1'b0, '0, '0, '0);
    chk({nm, ".acked"}, 32'(done), 32'd1);
    chk({nm, ".latency"}, 32'(lat), 32'd3);
    chk({nm, ".we_cycles"}, 32'(wec), (we != 4'b0000) ? 32'd1 : 32'd0);
    chk({nm, ".dat_r"}, rd, exp);
    chk({nm, ".other_ack"}, 32'(oth_ack), 32'd0);
    chk({nm, ".other_dat_hold"}, (m == 0) ? m1_dat_r : m0_dat_r, oth_dat);
    if (done) begin
      shadow_wr(adr, we, d);
      if (m == 0) g0++; else g1++;
    end
  endtask

  typedef struct {
    string       nm;
    int          m;
    logic [3:0]  we;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [1:0]  ackv;
    logic [1:0]  expv;
    logic        pend [2];
    logic [3:0]  pwe [2];
    logic [15:0] padr [2];
    logic [31:0] pdat [2];
    int          tst [2];
    logic        ok, ack;
    logic [31:0] rd;
    logic [5:0]  widx;

    tbl[0] = '{"rd_m0_10",   0, 4'b0000, 16'h0010, 32'h0,        32'h13121110};
    tbl[1] = '{"wr_m1_20",   1, 4'b0011, 16'h0020, 32'hDEADBEEF, 32'h23222120};
    tbl[2] = '{"rd_m1_20",   1, 4'b0000, 16'h0020, 32'h0,        32'h2322BEEF};
    tbl[3] = '{"wr_m0_30",   0, 4'b1000, 16'h0030, 32'hAABBCCDD, 32'h33323130};
    tbl[4] = '{"rd_m0_30",   0, 4'b0000, 16'h0030, 32'h0,        32'hAA323130};
    tbl[5] = '{"wr_m1_44",   1, 4'b1111, 16'h0044, 32'h01020304, 32'h47464544};
    tbl[6] = '{"rd_m0_44",   0, 4'b0000, 16'h0044, 32'h0,        32'h01020304};

    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
    g0 = 0; g1 = 0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst.m0_ack", 32'(m0_ack), 32'd0);
    chk("rst.m1_ack", 32'(m1_ack), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_adr", 32'(mem_adr), 32'd0);
    chk("rst.mem_di", mem_di, 32'd0);
    chk("rst.m0_dat_r", m0_dat_r, 32'd0);
    chk("rst.m1_dat_r", m1_dat_r, 32'd0);
    chk("rst.m0_grants", 32'(m0_grants), 32'd0);
    chk("rst.m1_grants", 32'(m1_grants), 32'd0);
    sys_rst = 1'b0;

    // Directed table of isolated accesses
    for (int i = 0; i < 7; i++)
      do_access(tbl[i].nm, tbl[i].m, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].exp);

`ifdef HM_MEM_ARB_STATS_EN
    chk("stats.m0_dir", 32'(m0_grants), 32'(g0));
    chk("stats.m1_dir", 32'(m1_grants), 32'(g1));
`endif

    // Simultaneous requests after reset: m0 first, then strict alternation every 3 cycles
    do_reset();
    drive(0, 1'b1, 4'b0000, 16'h0050, '0);
    drive(1, 1'b1, 4'b0000, 16'h0060, '0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge sys_clk);
      ackv = {m1_ack, m0_ack};
      expv = (k % 6 == 3) ? 2'b01 : (k % 6 == 0) ? 2'b10 : 2'b00;
      chk($sformatf("tie.acks_c%0d", k), 32'(ackv), 32'(expv));
      if (m0_ack) begin chk("tie.m0_dat", m0_dat_r, shadow[8'h14]); g0++; end
      if (m1_ack) begin chk("tie.m1_dat", m1_dat_r, shadow[8'h18]); g1++; end
    end
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    repeat (2) @(negedge sys_clk);
`ifdef HM_MEM_ARB_STATS_EN
    chk("stats.m0_tie", 32'(m0_grants), 32'd2);
    chk("stats.m1_tie", 32'(m1_grants), 32'd2);
`endif

    // Reset during the issue cycle of a write aborts it
    @(negedge sys_clk);
    drive(0, 1'b1, 4'b1111, 16'h0040, 32'h55555555);
    @(negedge sys_clk);
    chk("abort.issue_we", 32'(mem_we), 32'hF);
    sys_rst = 1'b1;
    #1;
    chk("abort.we_drop", 32'(mem_we), 32'd0);
    chk("abort.adr_clr", 32'(mem_adr), 32'd0);
    chk("abort.di_clr", mem_di, 32'd0);
    drive(0, 1'b0, '0, '0, '0);
    ok = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      if (m0_ack | m1_ack) ok = 1'b1;
    end
    chk("abort.no_ack", 32'(ok), 32'd0);
    sys_rst = 1'b0;
    g0 = 0; g1 = 0;
    do_access("abort.readback", 0, 4'b0000, 16'h0040, '0, 32'h43424140);

    // Random two-requester traffic checked against the shadow memory
    for (int m = 0; m < 2; m++) begin pend[m] = 1'b0; pwe[m] = '0; padr[m] = '0; pdat[m] = '0; tst[m] = 0; end
    for (int cyc = 0; cyc < 620; cyc++) begin
      @(negedge sys_clk);
      if (mem_we != 4'b0000) begin
        ok = 1'b0;
        for (int m = 0; m < 2; m++)
          if (pend[m] && pwe[m] == mem_we && padr[m] == mem_adr && pdat[m] == mem_di) ok = 1'b1;
        chk("rnd.we_owner", 32'(ok), 32'd1);
      end
      if (m0_ack | m1_ack) chk("rnd.ack_excl", 32'(m0_ack & m1_ack), 32'd0);
      for (int m = 0; m < 2; m++) begin
        ack = (m == 0) ? m0_ack : m1_ack;
        rd  = (m == 0) ? m0_dat_r : m1_dat_r;
        if (ack) begin
          chk($sformatf("rnd.m%0d_spurious", m), 32'(pend[m]), 32'd1);
          if (pend[m]) begin
            chk($sformatf("rnd.m%0d_dat@%h", m, padr[m]), rd, shadow[padr[m][9:2]]);
            chk($sformatf("rnd.m%0d_latency", m), 32'((cyc - tst[m]) <= 6), 32'd1);
            shadow_wr(padr[m], pwe[m], pdat[m]);
            if (m == 0) g0++; else g1++;
          end
          pend[m] = 1'b0;
          drive(m, 1'b0, '0, '0, '0);
        end else if (pend[m] && (cyc - tst[m]) > 6) begin
          chk($sformatf("rnd.m%0d_timeout", m), 32'd1, 32'd0);
          pend[m] = 1'b0;
          drive(m, 1'b0, '0, '0, '0);
        end else if (!pend[m] && cyc < 600 && $urandom_range(0, 2) == 0) begin
          widx    = 6'($urandom_range(0, 63));
          pwe[m]  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
          padr[m] = {8'h00, widx, 2'b00};
          pdat[m] = $urandom;
          tst[m]  = cyc;
          pend[m] = 1'b1;
          drive(m, 1'b1, pwe[m], padr[m], pdat[m]);
        end
      end
    end
    chk("rnd.drained", 32'(pend[0] | pend[1]), 32'd0);

`ifdef HM_MEM_ARB_STATS_EN
    chk("stats.m0_final", 32'(m0_grants), 32'(g0));
    chk("stats.m1_final", 32'(m1_grants), 32'(g1));
`else
    chk("stats.m0_off", 32'(m0_grants), 32'd0);
    chk("stats.m1_off", 32'(m1_grants), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
